// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter: launches one single-cycle TX_DATA_VALID
// per frame while the transmitter is idle and holds TX_P_DATA until the next launch.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    WR_EN,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
    input  logic                    TX_BUSY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   wr_accept;
    logic                   launch;

    // FULL/EMPTY are judged on the pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign FULL      = (count_q == CW'(DEPTH));
    assign EMPTY     = (count_q == '0);
    assign wr_accept = WR_EN && !FULL;
    assign launch    = (state_q == IDLE) && !EMPTY && !TX_BUSY;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path can infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        overflow_d = WR_EN && FULL;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({wr_accept, launch})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (launch) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    assign COUNT         = count_q;
    assign OVERFLOW      = overflow_q;
    assign TX_P_DATA     = tx_data_q;
    assign TX_DATA_VALID = tx_valid_q;

    a_valid_single: assert property (@(posedge CLK) disable iff (!RST)
        TX_DATA_VALID |=> !TX_DATA_VALID);

    a_full_empty_exclusive: assert property (@(posedge CLK) disable iff (!RST)
        !(FULL && EMPTY));

    a_data_held_mid_frame: assert property (@(posedge CLK) disable iff (!RST)
        (state_q != IDLE) |=> $stable(TX_P_DATA));

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised scoreboard bench for uart_tx_feeder with a behavioural transmitter
// busy model and an occupancy/launch reference model.
module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          WR_EN = 1'b0;
    logic          FULL, EMPTY, OVERFLOW, TX_DATA_VALID;
    logic [3:0]    COUNT;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_BUSY;

    logic force_busy = 1'b0;
    logic frame_busy = 1'b0;
    assign TX_BUSY = force_busy | frame_busy;

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .WR_DATA       (WR_DATA),
        .WR_EN         (WR_EN),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .COUNT         (COUNT),
        .OVERFLOW      (OVERFLOW),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transmitter handshake phase and FIFO occupancy.
    typedef enum {PH_READY, PH_STARTING, PH_SENDING} phase_e;
    phase_e        m_phase = PH_READY;
    int            m_occ = 0;
    bit            m_valid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            full_pre, m_launch;
    logic [DW-1:0] sb_q[$];
    int            cyc = 0;
    int            fall_edge = -1;
    bit            prev_busy = 1'b0;

    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            m_phase = PH_READY;
            m_occ   = 0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            sb_q.delete();
        end else begin
            cyc++;
            if (prev_busy && !TX_BUSY) fall_edge = cyc;
            prev_busy = TX_BUSY;
            full_pre  = (m_occ == DEPTH);
            m_launch  = (m_phase == PH_READY) && (m_occ != 0) && !TX_BUSY;
            m_ovf     = WR_EN && full_pre;
            m_valid   = m_launch;
            if (m_launch) begin
                m_occ--;
                m_phase = PH_STARTING;
            end else if (m_phase == PH_STARTING && TX_BUSY) begin
                m_phase = PH_SENDING;
            end else if (m_phase == PH_SENDING && !TX_BUSY) begin
                m_phase = PH_READY;
            end
            if (WR_EN && !full_pre) begin
                m_occ++;
                sb_q.push_back(WR_DATA);
            end
        end
    end

    // Transmitter model: busy rises start_delay cycles after the pulse, lasts frame_len cycles.
    int start_delay = 1;
    int frame_len   = 11;
    int start_cnt   = 0;
    int busy_cnt    = 0;

    initial forever begin
        @(negedge CLK);
        if (start_cnt > 0) begin
            start_cnt--;
            if (start_cnt == 0) begin
                frame_busy = 1'b1;
                busy_cnt   = frame_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) frame_busy = 1'b0;
        end
        if (TX_DATA_VALID === 1'b1) start_cnt = start_delay;
    end

    // Monitor: compares every cycle, pops the scoreboard on each DUT launch.
    logic [DW-1:0] exp_hold = '0;
    int            pulses = 0;
    bit            strict_gap = 1'b0;
    int            strict_start = 0;

    initial forever begin
        @(negedge CLK);
        if (!RST) exp_hold = '0;
        check("tx_data_valid", 32'(TX_DATA_VALID), 32'(m_valid));
        check("count", 32'(COUNT), 32'(m_occ));
        check("full", 32'(FULL), 32'(m_occ == DEPTH));
        check("empty", 32'(EMPTY), 32'(m_occ == 0));
        check("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (TX_DATA_VALID === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0) check("unexpected_launch", 32'(TX_DATA_VALID), 32'(0));
            else exp_hold = sb_q.pop_front();
            if (strict_gap && fall_edge > strict_start)
                check("launch_gap", 32'(cyc - fall_edge), 32'(1));
        end
        check("tx_p_data", 32'(TX_P_DATA), 32'(exp_hold));
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(m_occ == 0 && sb_q.size() == 0 && m_phase == PH_READY &&
                 !TX_BUSY && start_cnt == 0) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(n >= 1000), 32'(0));
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_count", 32'(COUNT), 32'(0));
        check("rst_empty", 32'(EMPTY), 32'(1));
        check("rst_full", 32'(FULL), 32'(0));
        check("rst_overflow", 32'(OVERFLOW), 32'(0));
        check("rst_valid", 32'(TX_DATA_VALID), 32'(0));
        check("rst_data", 32'(TX_P_DATA), 32'(0));
        #2 RST = 1'b1;

        // Single byte
        @(negedge CLK);
        p0 = pulses;
        WR_EN = 1'b1; WR_DATA = 8'hA5;
        @(negedge CLK);
        WR_EN = 1'b0;
        check("single_empty_after_write", 32'(EMPTY), 32'(0));
        @(negedge CLK);
        check("single_valid", 32'(TX_DATA_VALID), 32'(1));
        check("single_data", 32'(TX_P_DATA), 32'(8'hA5));
        check("single_empty_after_pop", 32'(EMPTY), 32'(1));
        repeat (8) begin
            @(negedge CLK);
            check("single_hold", 32'(TX_P_DATA), 32'(8'hA5));
        end
        wait_drain("single_drain_timeout");
        check("single_pulses", 32'(pulses - p0), 32'(1));

        // Burst ordering with exact back-to-back launch spacing
        p0 = pulses;
        strict_start = cyc;
        strict_gap = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            @(negedge CLK);
        end
        WR_EN = 1'b0;
        wait_drain("burst_drain_timeout");
        strict_gap = 1'b0;
        check("burst_pulses", 32'(pulses - p0), 32'(8));

        // Overflow while the transmitter is held busy
        p0 = pulses;
        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                check("ovf_full_after_8", 32'(FULL), 32'(1));
                check("ovf_count_after_8", 32'(COUNT), 32'(8));
            end
            WR_EN = 1'b1; WR_DATA = 8'(8'h20 + i);
            @(negedge CLK);
        end
        WR_EN = 1'b0;
        check("ovf_pulse", 32'(OVERFLOW), 32'(1));
        check("ovf_count_after_9", 32'(COUNT), 32'(8));
        @(negedge CLK);
        check("ovf_pulse_ends", 32'(OVERFLOW), 32'(0));

        // Full FIFO, write on the launch edge: pop happens, write is dropped
        force_busy = 1'b0;
        WR_EN = 1'b1; WR_DATA = 8'hEE;
        @(negedge CLK);
        WR_EN = 1'b0;
        check("fullpop_overflow", 32'(OVERFLOW), 32'(1));
        check("fullpop_count", 32'(COUNT), 32'(7));
        check("fullpop_valid", 32'(TX_DATA_VALID), 32'(1));
        check("fullpop_data", 32'(TX_P_DATA), 32'(8'h20));
        wait_drain("ovf_drain_timeout");
        check("ovf_pulses", 32'(pulses - p0), 32'(8));

        // Wrap-around: random bytes, random gaps, random short frames
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            start_delay = $urandom_range(1, 2);
            frame_len   = $urandom_range(1, 2);
            WR_EN = 1'b1; WR_DATA = 8'($urandom);
            @(negedge CLK);
            WR_EN = 1'b0;
            repeat ($urandom_range(4, 8)) @(negedge CLK);
        end
        wait_drain("wrap_drain_timeout");
        check("wrap_pulses", 32'(pulses - p0), 32'(20));

        // Reset mid-frame with three bytes queued
        start_delay = 1;
        frame_len   = 11;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(8'h40 + i);
            @(negedge CLK);
        end
        WR_EN = 1'b0;
        check("midrst_count_before", 32'(COUNT), 32'(3));
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("midrst_count", 32'(COUNT), 32'(0));
        check("midrst_empty", 32'(EMPTY), 32'(1));
        check("midrst_full", 32'(FULL), 32'(0));
        check("midrst_valid", 32'(TX_DATA_VALID), 32'(0));
        check("midrst_data", 32'(TX_P_DATA), 32'(0));
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        p0 = pulses;
        repeat (20) @(negedge CLK);
        check("midrst_no_launch", 32'(pulses - p0), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
